// File: rtl/seven_seg_scan_decoder_if.sv
// rtl/seven_seg_scan_decoder_if.sv - scanned display pins in, decoded frame out
interface seven_seg_scan_decoder_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] num;
  logic        valid;
  logic        err;

  modport master (output seg, output an, input num, input valid, input err);
  modport slave  (input seg, input an, output num, output valid, output err);
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// rtl/seven_seg_scan_decoder.sv - samples multiplexed seven-segment pins and rebuilds the 16-bit value
// Optional macro SEG_DEC_ERR_EN: invalid patterns pulse err and restart the frame.
module seven_seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seven_seg_scan_decoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  state_t      state_q, state_d;
  logic [10:0] smp_q, smp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] num_q, num_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        chg;
  logic        capture;
  logic        dec_ok;
  logic [3:0]  dec_nib;
  logic [1:0]  dig;
  logic [3:0]  mask_new;

  function automatic logic one_hot_low(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic [1:0] digit_of(input logic [3:0] a);
    case (a)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // {ok, nibble}; patterns outside the table decode as not ok
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: return 5'h10;
      7'h79: return 5'h11;
      7'h24: return 5'h12;
      7'h30: return 5'h13;
      7'h19: return 5'h14;
      7'h12: return 5'h15;
      7'h02: return 5'h16;
      7'h78: return 5'h17;
      7'h00: return 5'h18;
      7'h10: return 5'h19;
      7'h08: return 5'h1A;
      7'h03: return 5'h1B;
      7'h46: return 5'h1C;
      7'h21: return 5'h1D;
      7'h06: return 5'h1E;
      7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    smp_d    = {bus.an, bus.seg};
    chg      = (smp_d != smp_q);
    cnt_d    = chg ? 8'd1 : ((cnt_q >= STABLE) ? STABLE : cnt_q + 8'd1);
    state_d  = state_q;
    mask_d   = mask_q;
    frame_d  = frame_q;
    num_d    = num_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    capture  = 1'b0;
    {dec_ok, dec_nib} = decode(smp_q[6:0]);
    dig      = digit_of(smp_q[10:7]);
    mask_new = mask_q | (4'b0001 << dig);

    // Next state looks at the incoming sample so a capture lands exactly
    // STABLE_CYCLES-1 edges after the first sampling edge of a new value.
    case (state_q)
      IDLE: begin
        if (one_hot_low(smp_d[10:7])) state_d = SETTLE;
      end
      SETTLE: begin
        if (chg) begin
          state_d = one_hot_low(smp_d[10:7]) ? SETTLE : IDLE;
        end else if (cnt_d == STABLE) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (chg) state_d = one_hot_low(smp_d[10:7]) ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (dec_ok) begin
        frame_d[4*dig +: 4] = dec_nib;
        if (mask_new == 4'b1111) begin
          num_d   = frame_d;
          valid_d = 1'b1;
          mask_d  = 4'b0000;
        end else begin
          mask_d  = mask_new;
        end
      end else begin
`ifdef SEG_DEC_ERR_EN
        err_d  = 1'b1;
        mask_d = 4'b0000;
`else
        err_d  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      smp_q   <= {4'hF, 7'h7F};
      cnt_q   <= 8'd0;
      mask_q  <= 4'b0000;
      frame_q <= 16'h0000;
      num_q   <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.num   = num_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule
